debounce_edge: RTL and testbench

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

---
 rtl/debounce_edge_pkg.sv | 20 ++
 rtl/debounce_counter.sv | 27 ++
 rtl/debounce_edge.sv | 104 ++++++++++
 tb/tb_debounce_edge.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/debounce_edge_pkg.sv
// debounce_edge_pkg: FSM state encoding and parameter defaults shared by the debounce_edge slice.
package debounce_edge_pkg;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_CHK_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_CHK_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE        = ST_IDLE,
        CHK_PRESS   = ST_CHK_PRESS,
        PRESSED     = ST_PRESSED,
        CHK_RELEASE = ST_CHK_RELEASE
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 20;
    localparam int DEF_LONG_CYCLES     = 200;
    localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/debounce_counter.sv
// debounce_counter: CNT_W-bit counter with clear, enable and terminal-count compare.
module debounce_counter
    import debounce_edge_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // clr together with en restarts the count at 1 (first matching sample).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || en)
            cnt <= clr ? CNT_W'(en) : cnt + CNT_W'(en);
    end

    assign tc = cnt == tc_val;

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: button debouncer with press/release/long-press pulses and a wrapping press counter.
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             long_done;
    logic             seek_release;
    logic             diff;
    logic             chk;
    logic             deb_tc;
    logic             deb_clr;
    logic             deb_en;

    // The debounce counter runs while the input differs from the level being held.
    always_comb begin
        seek_release = state == PRESSED || state == CHK_RELEASE;
        diff         = sync_in ^ seek_release;
        chk          = state == CHK_PRESS || state == CHK_RELEASE;
        deb_en       = diff && !(chk && deb_tc);
        deb_clr      = !chk || !diff || deb_tc;
    end

    debounce_counter #(.CNT_W(CNT_W)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (deb_clr),
        .en     (deb_en),
        .tc_val (DEB_TC),
        .tc     (deb_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: if (sync_in) state <= CHK_PRESS;
                CHK_PRESS: begin
                    if (!sync_in)
                        state <= IDLE;
                    else if (deb_tc) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
                    end
                end
                PRESSED: begin
                    if (!sync_in)
                        state <= CHK_RELEASE;
                    else begin
                        if (hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
                        if (hold_cnt == LONG_TC && !long_done) begin
                            long_pulse <= 1'b1;
                            long_done  <= 1'b1;
                        end
                    end
                end
                CHK_RELEASE: begin
                    // A bounce back to 1 resumes the same press with hold state intact.
                    if (sync_in)
                        state <= PRESSED;
                    else if (deb_tc) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: scoreboard bench; stimulus queues expected pulse events, a monitor pops and compares them.
module tb_debounce_edge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_in = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    typedef struct {
        logic [2:0] kind;
        int         at;
        logic [7:0] cnt;
        logic       lvl;
    } ev_t;

    localparam logic [2:0] K_PRESS = 3'b001;
    localparam logic [2:0] K_REL   = 3'b010;
    localparam logic [2:0] K_LONG  = 3'b100;

    ev_t        q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_cnt = 8'd0;
    int         base;

    debounce_edge #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sync_in       (sync_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (press_pulse || release_pulse || long_pulse) begin
            ev_t e;
            logic [2:0] got;
            got = {long_pulse, release_pulse, press_pulse};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: pulses=%b at edge %0d, none expected", got, cyc);
            end else begin
                e = q.pop_front();
                if (got != e.kind || cyc != e.at || press_count != e.cnt || btn_level != e.lvl) begin
                    errors++;
                    $display("FAIL event: got pulses=%b edge=%0d count=%0d level=%b, want pulses=%b edge=%0d count=%0d level=%b",
                             got, cyc, press_count, btn_level, e.kind, e.at, e.cnt, e.lvl);
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            sync_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [2:0] kind, input int at);
        if (kind == K_PRESS) exp_cnt = exp_cnt + 8'd1;
        q.push_back('{kind, at, exp_cnt, kind != K_REL});
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_level"}, btn_level, 0);
        check({name, "_pulses"}, {long_pulse, release_pulse, press_pulse}, 0);
        check({name, "_count"}, press_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Clean press held 30 edges, long press, then clean release.
        base = cyc;
        expect_ev(K_PRESS, base + 4);
        expect_ev(K_LONG, base + 14);
        expect_ev(K_REL, base + 34);
        drive(1'b1, 30);
        drive(1'b0, 6);
        check("after_release_level", btn_level, 0);
        check("after_release_count", press_count, 1);

        // Glitchy input never reaches four consecutive ones.
        drive(1'b1, 3);
        drive(1'b0, 1);
        drive(1'b1, 3);
        drive(1'b0, 3);
        check("glitch_level", btn_level, 0);
        check("glitch_count", press_count, 1);

        // Release bounce 0,0,1 delays the long press by the three frozen edges.
        base = cyc;
        expect_ev(K_PRESS, base + 4);
        expect_ev(K_LONG, base + 17);
        expect_ev(K_REL, base + 33);
        drive(1'b1, 6);
        drive(1'b0, 2);
        drive(1'b1, 1);
        check("bounce_level", btn_level, 1);
        drive(1'b1, 20);
        drive(1'b0, 6);
        check("bounce_count", press_count, 2);

        // Reset in CHK_PRESS with deb_cnt=3 aborts the press.
        drive(1'b1, 3);
        rst_n = 1'b0;
        #2;
        check_idle_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        base = cyc;
        expect_ev(K_PRESS, base + 4);
        expect_ev(K_REL, base + 8);
        drive(1'b1, 4);
        drive(1'b0, 4);
        check("post_reset_count", press_count, 1);

        // 255 more presses bring the total to 256, wrapping the counter to 0.
        for (int p = 0; p < 255; p++) begin
            base = cyc;
            expect_ev(K_PRESS, base + 4);
            expect_ev(K_REL, base + 8);
            drive(1'b1, 4);
            drive(1'b0, 4);
        end
        check("wrap_count", press_count, 0);
        check("wrap_level", btn_level, 0);

        drive(1'b0, 5);
        check("pending_events", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
